// File: rtl/mem_arbiter_if.sv
// Bus bundle between the mem_arbiter and its two requesters plus the unified memory.
// The slave view belongs to the arbiter; the master view is the requester/memory side.
interface mem_arbiter_if;
  logic        ibus_req_i;
  logic [31:0] ibus_addr_i;
  logic        ibus_gnt_o;
  logic        ibus_rvalid_o;
  logic [31:0] ibus_rdata_o;
  logic        ibus_stall_o;

  logic        dbus_req_i;
  logic        dbus_we_i;
  logic [31:0] dbus_addr_i;
  logic [31:0] dbus_wdata_i;
  logic        dbus_gnt_o;
  logic        dbus_rvalid_o;
  logic [31:0] dbus_rdata_o;
  logic        dbus_stall_o;

  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  ibus_req_i, ibus_addr_i,
    input  dbus_req_i, dbus_we_i, dbus_addr_i, dbus_wdata_i,
    input  mem_rdata_i,
    output ibus_gnt_o, ibus_rvalid_o, ibus_rdata_o, ibus_stall_o,
    output dbus_gnt_o, dbus_rvalid_o, dbus_rdata_o, dbus_stall_o,
    output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );

  modport master (
    output ibus_req_i, ibus_addr_i,
    output dbus_req_i, dbus_we_i, dbus_addr_i, dbus_wdata_i,
    output mem_rdata_i,
    input  ibus_gnt_o, ibus_rvalid_o, ibus_rdata_o, ibus_stall_o,
    input  dbus_gnt_o, dbus_rvalid_o, dbus_rdata_o, dbus_stall_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (ibus)
// and the MEM-stage data bus (dbus). One transaction in flight at a time; data
// accesses win ties, and a starvation counter forces a fetch through after
// STARVE_MAX consecutive contested data wins.
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       OWNER_IBUS = 1'b0;
  localparam logic       OWNER_DBUS = 1'b1;

  state_t     r_state;
  logic       r_owner;
  logic [2:0] r_latCnt;
  logic [3:0] r_starveCnt;

  logic w_idle;
  logic w_starved;
  logic w_ibusWin;
  logic w_dbusWin;
  logic w_done;
  logic w_ibusDone;
  logic w_dbusDone;

  // Pick a winner while idle: dbus by default, ibus when alone or when it has been starved.
  always_comb begin
    w_idle    = ~rst & (r_state == ST_IDLE);
    w_starved = (r_starveCnt == STARVE_LIM);
    w_ibusWin = w_idle & bus.ibus_req_i & (~bus.dbus_req_i | w_starved);
    w_dbusWin = w_idle & bus.dbus_req_i & ~(bus.ibus_req_i & w_starved);
  end

  // Completion is the last WAIT cycle; steer it to whoever owns the transaction.
  always_comb begin
    w_done     = ~rst & (r_state == ST_WAIT) & (r_latCnt == 3'd0);
    w_ibusDone = w_done & (r_owner == OWNER_IBUS);
    w_dbusDone = w_done & (r_owner == OWNER_DBUS);
  end

  // Memory command is driven only in the issue cycle, straight from the winner's inputs.
  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_re_o    = 1'b0;
    if (w_ibusWin) begin
      bus.mem_addr_o = bus.ibus_addr_i;
      bus.mem_re_o   = 1'b1;
    end else if (w_dbusWin) begin
      bus.mem_addr_o  = bus.dbus_addr_i;
      bus.mem_wdata_o = bus.dbus_wdata_i;
      bus.mem_we_o    = bus.dbus_we_i;
      bus.mem_re_o    = ~bus.dbus_we_i;
    end
  end

  // Requester-facing grant, completion, data and stall lines, all forced low in reset.
  always_comb begin
    bus.ibus_gnt_o    = w_ibusWin;
    bus.dbus_gnt_o    = w_dbusWin;
    bus.ibus_rvalid_o = w_ibusDone;
    bus.dbus_rvalid_o = w_dbusDone;
    bus.ibus_rdata_o  = rst ? 32'd0 : bus.mem_rdata_i;
    bus.dbus_rdata_o  = rst ? 32'd0 : bus.mem_rdata_i;
    bus.ibus_stall_o  = ~rst & bus.ibus_req_i & ~w_ibusDone;
    bus.dbus_stall_o  = ~rst & bus.dbus_req_i & ~w_dbusDone;
  end

  // Sequencer: latch owner and latency on a grant, count down, and track fetch starvation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWNER_IBUS;
      r_latCnt    <= 3'd0;
      r_starveCnt <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ibusWin || w_dbusWin) begin
            r_state  <= ST_WAIT;
            r_owner  <= w_dbusWin ? OWNER_DBUS : OWNER_IBUS;
            r_latCnt <= LAT_LOAD;
          end
          if (w_ibusWin) begin
            r_starveCnt <= 4'd0;
          end else if (w_dbusWin && bus.ibus_req_i && (r_starveCnt != STARVE_LIM)) begin
            r_starveCnt <= r_starveCnt + 4'd1;
          end
        end
        ST_WAIT: begin
          if (r_latCnt == 3'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_latCnt <= r_latCnt - 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: three copies with MEM_LAT = 1, 2, 3 (STARVE_MAX = 4)
// see the same input stream. A transaction-level model per copy predicts every
// output each cycle; directed literal expectations pin the scenarios of interest.
module tb_mem_arbiter;

  localparam int NINST  = 3;
  localparam int STARVE = 4;

  logic        clk;
  logic        rst;
  logic        ibusReq;
  logic [31:0] ibusAddr;
  logic        dbusReq;
  logic        dbusWe;
  logic [31:0] dbusAddr;
  logic [31:0] dbusWdata;
  logic [31:0] memRdata;

  logic [NINST-1:0] oGntI, oGntD, oRvI, oRvD, oStI, oStD, oWe, oRe;
  logic [31:0]      oAddr  [NINST];
  logic [31:0]      oWdata [NINST];
  logic [31:0]      oRdI   [NINST];
  logic [31:0]      oRdD   [NINST];

  int checks   = 0;
  int failures = 0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One DUT per latency, each on its own interface, all fed from the shared stimulus.
  for (genvar g = 0; g < NINST; g++) begin : gInst
    mem_arbiter_if bus ();

    mem_arbiter #(.MEM_LAT(g + 1), .STARVE_MAX(STARVE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.ibus_req_i   = ibusReq;
    assign bus.ibus_addr_i  = ibusAddr;
    assign bus.dbus_req_i   = dbusReq;
    assign bus.dbus_we_i    = dbusWe;
    assign bus.dbus_addr_i  = dbusAddr;
    assign bus.dbus_wdata_i = dbusWdata;
    assign bus.mem_rdata_i  = memRdata;

    assign oGntI[g]  = bus.ibus_gnt_o;
    assign oGntD[g]  = bus.dbus_gnt_o;
    assign oRvI[g]   = bus.ibus_rvalid_o;
    assign oRvD[g]   = bus.dbus_rvalid_o;
    assign oStI[g]   = bus.ibus_stall_o;
    assign oStD[g]   = bus.dbus_stall_o;
    assign oWe[g]    = bus.mem_we_o;
    assign oRe[g]    = bus.mem_re_o;
    assign oAddr[g]  = bus.mem_addr_o;
    assign oWdata[g] = bus.mem_wdata_o;
    assign oRdI[g]   = bus.ibus_rdata_o;
    assign oRdD[g]   = bus.dbus_rdata_o;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait to the sampling edge.
  task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [31:0] md);
    @(posedge clk);
    #1;
    rst       = r;
    ibusReq   = ir;
    ibusAddr  = ia;
    dbusReq   = dr;
    dbusWe    = dw;
    dbusAddr  = da;
    dbusWdata = dwd;
    memRdata  = md;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  // Transaction-level model: busy flag, completion cycle, owner and starvation count per copy.
  int   mBusy   [NINST];
  int   mDoneAt [NINST];
  int   mOwnerD [NINST];
  int   mStarve [NINST];
  logic eGntI, eGntD, eRvI, eRvD, eStI, eStD, eWe, eRe;
  logic [31:0] eAddr, eWdata, eRd;

  initial begin : compareProc
    int cyc;
    cyc = 0;
    for (int k = 0; k < NINST; k++) begin
      mBusy[k] = 0; mDoneAt[k] = 0; mOwnerD[k] = 0; mStarve[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NINST; k++) begin
        eGntI = 0; eGntD = 0; eRvI = 0; eRvD = 0; eWe = 0; eRe = 0;
        eAddr = 0; eWdata = 0;
        eRd   = rst ? 32'd0 : memRdata;
        if (rst) begin
          mBusy[k]   = 0;
          mStarve[k] = 0;
        end else if (mBusy[k] == 0) begin
          if (ibusReq && (!dbusReq || mStarve[k] == STARVE)) begin
            eGntI = 1; eRe = 1; eAddr = ibusAddr;
            mStarve[k] = 0;
            mBusy[k] = 1; mDoneAt[k] = cyc + k + 1; mOwnerD[k] = 0;
          end else if (dbusReq) begin
            eGntD = 1; eWe = dbusWe; eRe = !dbusWe; eAddr = dbusAddr; eWdata = dbusWdata;
            if (ibusReq && mStarve[k] < STARVE) mStarve[k] = mStarve[k] + 1;
            mBusy[k] = 1; mDoneAt[k] = cyc + k + 1; mOwnerD[k] = 1;
          end
        end else if (cyc == mDoneAt[k]) begin
          if (mOwnerD[k] == 1) eRvD = 1; else eRvI = 1;
          mBusy[k] = 0;
        end
        eStI = !rst && ibusReq && !eRvI;
        eStD = !rst && dbusReq && !eRvD;
        checkOutput($sformatf("L%0d.ibus_gnt@%0d", k + 1, cyc), 32'(oGntI[k]), 32'(eGntI));
        checkOutput($sformatf("L%0d.dbus_gnt@%0d", k + 1, cyc), 32'(oGntD[k]), 32'(eGntD));
        checkOutput($sformatf("L%0d.ibus_rvalid@%0d", k + 1, cyc), 32'(oRvI[k]), 32'(eRvI));
        checkOutput($sformatf("L%0d.dbus_rvalid@%0d", k + 1, cyc), 32'(oRvD[k]), 32'(eRvD));
        checkOutput($sformatf("L%0d.ibus_stall@%0d", k + 1, cyc), 32'(oStI[k]), 32'(eStI));
        checkOutput($sformatf("L%0d.dbus_stall@%0d", k + 1, cyc), 32'(oStD[k]), 32'(eStD));
        checkOutput($sformatf("L%0d.mem_we@%0d", k + 1, cyc), 32'(oWe[k]), 32'(eWe));
        checkOutput($sformatf("L%0d.mem_re@%0d", k + 1, cyc), 32'(oRe[k]), 32'(eRe));
        checkOutput($sformatf("L%0d.mem_addr@%0d", k + 1, cyc), oAddr[k], eAddr);
        checkOutput($sformatf("L%0d.mem_wdata@%0d", k + 1, cyc), oWdata[k], eWdata);
        if (rst || eRvI) checkOutput($sformatf("L%0d.ibus_rdata@%0d", k + 1, cyc), oRdI[k], eRd);
        if (rst || eRvD) checkOutput($sformatf("L%0d.dbus_rdata@%0d", k + 1, cyc), oRdD[k], eRd);
      end
      cyc++;
    end
  end

  // Directed scenarios with hand-computed expectations, then a mixed-traffic tail.
  initial begin : mainProc
    int sGntD [12];
    int sGntI [12];
    sGntD = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0};
    sGntI = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    rst = 1'b1; ibusReq = 0; ibusAddr = 0; dbusReq = 0; dbusWe = 0;
    dbusAddr = 0; dbusWdata = 0; memRdata = 0;

    // Reset held with both requests up: everything stays low.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 32'h0, 32'h1234_5678);
      checkOutput("rst.dbus_gnt", 32'(oGntD[1]), 32'd0);
      checkOutput("rst.ibus_gnt", 32'(oGntI[1]), 32'd0);
      checkOutput("rst.mem_re", 32'(oRe[1]), 32'd0);
      checkOutput("rst.ibus_stall", 32'(oStI[1]), 32'd0);
      checkOutput("rst.dbus_stall", 32'(oStD[1]), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0);
    checkOutput("postrst.dbus_gnt", 32'(oGntD[1]), 32'd1);
    checkOutput("postrst.ibus_gnt", 32'(oGntI[1]), 32'd0);
    checkOutput("postrst.mem_addr", oAddr[1], 32'h40);
    idleCycles(4);

    // Single fetch on the MEM_LAT=2 copy.
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("fetch.ibus_gnt", 32'(oGntI[1]), 32'd1);
    checkOutput("fetch.mem_re", 32'(oRe[1]), 32'd1);
    checkOutput("fetch.mem_addr", oAddr[1], 32'h100);
    checkOutput("fetch.stall_T", 32'(oStI[1]), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("fetch.stall_T1", 32'(oStI[1]), 32'd1);
    checkOutput("fetch.rvalid_T1", 32'(oRvI[1]), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0013);
    checkOutput("fetch.rvalid_T2", 32'(oRvI[1]), 32'd1);
    checkOutput("fetch.rdata_T2", oRdI[1], 32'h0000_0013);
    checkOutput("fetch.stall_T2", 32'(oStI[1]), 32'd0);
    idleCycles(4);

    // Contention on the MEM_LAT=1 copy: dbus write first, fetch right after.
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 32'h0);
    checkOutput("cont.dbus_gnt", 32'(oGntD[0]), 32'd1);
    checkOutput("cont.ibus_gnt", 32'(oGntI[0]), 32'd0);
    checkOutput("cont.mem_we", 32'(oWe[0]), 32'd1);
    checkOutput("cont.mem_re", 32'(oRe[0]), 32'd0);
    checkOutput("cont.mem_wdata", oWdata[0], 32'hDEAD_BEEF);
    checkOutput("cont.mem_addr", oAddr[0], 32'h2000);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 32'h0);
    checkOutput("cont.dbus_rvalid", 32'(oRvD[0]), 32'd1);
    checkOutput("cont.ibus_stall", 32'(oStI[0]), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("cont.ibus_gnt_T2", 32'(oGntI[0]), 32'd1);
    checkOutput("cont.mem_addr_T2", oAddr[0], 32'h300);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    idleCycles(4);

    // Starvation on the MEM_LAT=1 copy: four dbus wins, then ibus, then dbus again.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0);
      checkOutput($sformatf("starve.dbus_gnt[%0d]", i), 32'(oGntD[0]), 32'(sGntD[i]));
      checkOutput($sformatf("starve.ibus_gnt[%0d]", i), 32'(oGntI[0]), 32'(sGntI[i]));
    end
    idleCycles(4);

    // Reset in the middle of a MEM_LAT=3 data read: no completion afterwards.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 32'h0);
    checkOutput("abort.dbus_gnt", 32'(oGntD[2]), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 32'h0);
    checkOutput("abort.rst_gnt", 32'(oGntD[2]), 32'd0);
    checkOutput("abort.rst_stall", 32'(oStD[2]), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h640, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("abort.idle_T2", 32'(oGntI[2]), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h640, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_0000);
    checkOutput("abort.no_rvalid_T3", 32'(oRvD[2]), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h640, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h640, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0777);
    checkOutput("abort.ibus_rvalid_T5", 32'(oRvI[2]), 32'd1);
    checkOutput("abort.ibus_rdata_T5", oRdI[2], 32'h0000_0777);
    idleCycles(4);

    // Back-to-back fetches on the MEM_LAT=1 copy: grant every other cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      checkOutput($sformatf("b2b.ibus_gnt[%0d]", i), 32'(oGntI[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("b2b.ibus_rvalid[%0d]", i), 32'(oRvI[0]), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    idleCycles(4);

    // Mixed traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), $urandom(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                    $urandom(), $urandom());
    end
    idleCycles(4);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
